// File: rtl/stoch_avg_mat_ctrl_if.sv
// stoch_avg_mat_ctrl_if: host/matrix handshake bundle for the stochastic averaging matrix controller
interface stoch_avg_mat_ctrl_if #(
  parameter int NUM_ROWS = 3,
  parameter int NUM_COLS = 3,
  parameter int LEN_W    = 16
);
  logic                                          start;
  logic [LEN_W-1:0]                              len;
  logic                                          abort;
  logic [NUM_ROWS-1:0][NUM_COLS-1:0]             y_in;
  logic                                          dp_clr_n;
  logic                                          busy;
  logic                                          done;
  logic [NUM_ROWS-1:0][NUM_COLS-1:0][LEN_W-1:0]  counts;
  modport master (output start, len, abort, y_in, input dp_clr_n, busy, done, counts);
  modport slave  (input start, len, abort, y_in, output dp_clr_n, busy, done, counts);
endinterface

// File: rtl/stoch_avg_mat_ctrl.sv
// stoch_avg_mat_ctrl: clears the averaging matrix, skips warm-up, then counts ones per element over len cycles
module stoch_avg_mat_ctrl #(
  parameter int NUM_ROWS   = 3,
  parameter int NUM_COLS   = 3,
  parameter int LEN_W      = 16,
  parameter int CLR_CYCLES = 2,
  parameter int WARMUP     = 4
) (
  input logic CLK,
  input logic nRST,
  stoch_avg_mat_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CLEAR, WARM, RUN, DONE} state_t;
  state_t state, nxt;
  logic [LEN_W-1:0] ph, ph_nxt, len_q;
  logic abort_ok, accept;
  assign abort_ok = bus.abort && (state == CLEAR || state == WARM || state == RUN);
  assign accept   = state == IDLE && bus.start;
  // ph counts down the remaining cycles of the current phase; reloaded on every entry
  always_comb begin
    nxt    = state;
    ph_nxt = ph - LEN_W'(1);
    case (state)
      IDLE: if (bus.start) begin
        nxt    = CLEAR;
        ph_nxt = LEN_W'(CLR_CYCLES - 1);
      end
      CLEAR: if (ph == '0) begin
        if (WARMUP != 0) begin
          nxt    = WARM;
          ph_nxt = LEN_W'(WARMUP - 1);
        end else begin
          nxt    = len_q == '0 ? DONE : RUN;
          ph_nxt = len_q - LEN_W'(1);
        end
      end
      WARM: if (ph == '0) begin
        nxt    = len_q == '0 ? DONE : RUN;
        ph_nxt = len_q - LEN_W'(1);
      end
      RUN:  if (ph == '0) nxt = DONE;
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (abort_ok) nxt = IDLE;
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state        <= IDLE;
      ph           <= '0;
      len_q        <= '0;
      bus.dp_clr_n <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.counts   <= '0;
    end else begin
      state        <= nxt;
      ph           <= ph_nxt;
      bus.dp_clr_n <= nxt != CLEAR;
      bus.busy     <= nxt != IDLE;
      bus.done     <= nxt == DONE;
      if (accept) len_q <= bus.len;
      if (accept || abort_ok) bus.counts <= '0;
      else if (state == RUN)
        for (int i = 0; i < NUM_ROWS; i++)
          for (int j = 0; j < NUM_COLS; j++)
            bus.counts[i][j] <= bus.counts[i][j] + LEN_W'(bus.y_in[i][j]);
    end
  end
endmodule

// File: tb/tb_stoch_avg_mat_ctrl.sv
// tb_stoch_avg_mat_ctrl: table-driven run vectors plus reset/async-reset sequences
module tb_stoch_avg_mat_ctrl;
  localparam int R = 3, C = 3, W = 16;
  typedef logic [R-1:0][C-1:0] ymat_t;
  typedef struct {
    int len;
    int mode;
    bit hold;
    int abort_at;
    int exp_done;
    int c00;
    int co;
  } vec_t;
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  int checks = 0;
  int failures = 0;
  vec_t v[8];
  stoch_avg_mat_ctrl_if #(.NUM_ROWS(R), .NUM_COLS(C), .LEN_W(W)) bus();
  stoch_avg_mat_ctrl #(.NUM_ROWS(R), .NUM_COLS(C), .LEN_W(W), .CLR_CYCLES(2), .WARMUP(4)) dut (
    .CLK(CLK), .nRST(nRST), .bus(bus)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic int cnt_bad(input int c00, input int co);
    int bad = 0;
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++)
        if (int'(bus.counts[i][j]) != ((i == 0 && j == 0) ? c00 : co)) bad++;
    return bad;
  endfunction
  // mode 0: all ones; mode 1: [0][0] high in WARM, then 1,0,1,0.. from first RUN cycle
  function automatic ymat_t ymode(input int mode, input int c);
    ymat_t y = '0;
    if (mode == 0) y = '1;
    else if (c >= 3 && c <= 6) y[0][0] = 1'b1;
    else if (c >= 7) y[0][0] = ((c - 7) % 2) == 0;
    return y;
  endfunction
  task automatic run_vec(input vec_t t, input int idx);
    int exp_end = t.exp_done != 0 ? t.exp_done : t.abort_at;
    int e_clr = 0, e_busy = 0, e_done = 0, e_cnt = 0;
    logic x_clr, x_busy, x_done;
    @(negedge CLK);
    bus.start = 1'b1;
    bus.len   = W'(t.len);
    bus.abort = t.abort_at == 0;
    bus.y_in  = ymode(t.mode, 0);
    @(posedge CLK); #1;
    for (int c = 1; c <= exp_end + 2; c++) begin
      bus.start = t.hold && c <= exp_end;
      bus.abort = c == t.abort_at;
      bus.y_in  = ymode(t.mode, c);
      x_clr  = !(c <= 2 && c <= exp_end);
      x_busy = c <= exp_end;
      x_done = c == t.exp_done;
      if (bus.dp_clr_n !== x_clr) e_clr++;
      if (bus.busy !== x_busy) e_busy++;
      if (bus.done !== x_done) e_done++;
      if (c == t.exp_done && cnt_bad(t.c00, t.co) != 0) e_cnt++;
      @(posedge CLK); #1;
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk($sformatf("v%0d dp_clr_n bad cycles", idx), e_clr, 0);
    chk($sformatf("v%0d busy bad cycles", idx), e_busy, 0);
    chk($sformatf("v%0d done bad cycles", idx), e_done, 0);
    chk($sformatf("v%0d counts bad (c00=%0d)", idx, bus.counts[0][0]), e_cnt + cnt_bad(t.c00, t.co), 0);
  endtask
  initial begin
    v[0] = '{len: 8,  mode: 0, hold: 0, abort_at: -1, exp_done: 15, c00: 8, co: 8};
    v[1] = '{len: 10, mode: 1, hold: 0, abort_at: -1, exp_done: 17, c00: 5, co: 0};
    v[2] = '{len: 0,  mode: 0, hold: 1, abort_at: -1, exp_done: 7,  c00: 0, co: 0};
    v[3] = '{len: 20, mode: 0, hold: 0, abort_at: 11, exp_done: 0,  c00: 0, co: 0};
    v[4] = '{len: 3,  mode: 0, hold: 0, abort_at: -1, exp_done: 10, c00: 3, co: 3};
    v[5] = '{len: 1,  mode: 1, hold: 0, abort_at: -1, exp_done: 8,  c00: 1, co: 0};
    v[6] = '{len: 2,  mode: 0, hold: 0, abort_at: 0,  exp_done: 9,  c00: 2, co: 2};
    v[7] = '{len: 4,  mode: 0, hold: 0, abort_at: 11, exp_done: 11, c00: 4, co: 4};
    bus.start = 1'b0;
    bus.len   = '0;
    bus.abort = 1'b0;
    bus.y_in  = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset dp_clr_n", int'(bus.dp_clr_n), 0);
    chk("reset busy", int'(bus.busy), 0);
    chk("reset done", int'(bus.done), 0);
    chk("reset counts bad", cnt_bad(0, 0), 0);
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK); #1;
    chk("post-release dp_clr_n", int'(bus.dp_clr_n), 1);
    chk("post-release busy", int'(bus.busy), 0);
    for (int k = 0; k < 8; k++) run_vec(v[k], k);
    // async reset in the middle of RUN
    @(negedge CLK);
    bus.start = 1'b1;
    bus.len   = W'(20);
    bus.y_in  = '1;
    @(posedge CLK); #1;
    bus.start = 1'b0;
    repeat (8) begin
      @(posedge CLK); #1;
    end
    chk("mid-run counts[0][0]", int'(bus.counts[0][0]), 2);
    chk("mid-run busy", int'(bus.busy), 1);
    #2 nRST = 1'b0;
    #1;
    chk("async dp_clr_n", int'(bus.dp_clr_n), 0);
    chk("async busy", int'(bus.busy), 0);
    chk("async done", int'(bus.done), 0);
    chk("async counts bad", cnt_bad(0, 0), 0);
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK); #1;
    chk("async post-release dp_clr_n", int'(bus.dp_clr_n), 1);
    run_vec(v[4], 8);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
